// File: rtl/spi_segment_scanner.sv
// Multi-digit 7-segment scanner with an oversampled mode-0 SPI command port.
// Frames are 16 bits {cmd, addr, data}. Digits are scanned one-hot, and selected digits can blink.
module spi_segment_scanner #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter logic [23:0] SCAN_COUNT  = 24'd10_000,
  parameter logic [23:0] BLINK_COUNT = 24'd10_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  spi_sclk,
  input  logic                  spi_mosi,
  input  logic                  spi_cs_n,
  output logic [7:0]            seg_out,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  frame_ok
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [3:0] {
    CMD_RAW   = 4'd1,
    CMD_HEX   = 4'd2,
    CMD_BLINK = 4'd3,
    CMD_CTRL  = 4'd4
  } cmd_e;

  // Synchronisers: [0],[1] are the 2-FF chain; [2] holds the previous synced value for edge detection.
  logic [2:0] sclk_q, cs_q;
  logic [1:0] mosi_q;

  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [15:0]           shift_q, shift_d;
  logic                  frame_ok_q, frame_ok_d;
  logic [7:0]            digit_q [NUM_DIGITS];
  logic [7:0]            digit_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic                  disp_en_q, disp_en_d;
  logic [23:0]           scan_cnt_q, scan_cnt_d;
  logic [23:0]           blink_cnt_q, blink_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  phase_q, phase_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;

  logic sclk_rise, cs_fall, cs_rise, cs_s, mosi_s;
  logic [3:0] f_cmd, f_addr;
  logic [7:0] f_data;
  logic [7:0] cur_seg;
  logic       cur_blink;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_s      = cs_q[1];
  assign mosi_s    = mosi_q[1];
  assign f_cmd     = shift_q[15:12];
  assign f_addr    = shift_q[11:8];
  assign f_data    = shift_q[7:0];

  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // SPI framing and register writes
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    frame_ok_d = 1'b0;
    digit_d    = digit_q;
    mask_d     = mask_q;
    disp_en_d  = disp_en_q;
    if (!ena) begin
      // Dropping the count makes any frame overlapping a disabled period fail the length check.
      bit_cnt_d = '0;
    end else if (cs_fall) begin
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (cs_rise) begin
      bit_cnt_d = '0;
      if (bit_cnt_q == 5'd16) begin
        frame_ok_d = 1'b1;
        case (f_cmd)
          CMD_RAW: begin
            for (int unsigned d = 0; d < NUM_DIGITS; d++)
              if (32'(f_addr) == d) digit_d[d] = f_data;
          end
          CMD_HEX: begin
            for (int unsigned d = 0; d < NUM_DIGITS; d++)
              if (32'(f_addr) == d) digit_d[d] = {f_data[7], hex7seg(f_data[3:0])};
          end
          CMD_BLINK: mask_d    = f_data[NUM_DIGITS-1:0];
          CMD_CTRL:  disp_en_d = f_data[0];
          default: ;
        endcase
      end
    end else if (sclk_rise && !cs_s) begin
      shift_d = {shift_q[14:0], mosi_s};
      if (bit_cnt_q != 5'd17) bit_cnt_d = bit_cnt_q + 5'd1;
    end
  end

  // Scan and blink timebases
  always_comb begin
    scan_cnt_d  = scan_cnt_q;
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (ena) begin
      if (scan_cnt_q == SCAN_COUNT - 24'd1) begin
        scan_cnt_d = '0;
        idx_d      = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        scan_cnt_d = scan_cnt_q + 24'd1;
      end
      if (blink_cnt_q == BLINK_COUNT - 24'd1) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 24'd1;
      end
    end
  end

  // Output register, driven from current idx and stored contents
  always_comb begin
    cur_seg   = '0;
    cur_blink = 1'b0;
    seg_d     = '0;
    en_d      = '0;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      if (32'(idx_q) == d) begin
        cur_seg   = digit_q[d];
        cur_blink = mask_q[d];
      end
    end
    if (ena && disp_en_q) begin
      for (int unsigned d = 0; d < NUM_DIGITS; d++)
        en_d[d] = (32'(idx_q) == d);
      if (!(cur_blink && phase_q)) seg_d = cur_seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q      <= '0;
      cs_q        <= '1;
      mosi_q      <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_ok_q  <= 1'b0;
      for (int unsigned d = 0; d < NUM_DIGITS; d++) digit_q[d] <= '0;
      mask_q      <= '0;
      disp_en_q   <= 1'b1;
      scan_cnt_q  <= '0;
      blink_cnt_q <= '0;
      idx_q       <= '0;
      phase_q     <= 1'b0;
      seg_q       <= '0;
      en_q        <= '0;
    end else begin
      sclk_q      <= {sclk_q[1:0], spi_sclk};
      cs_q        <= {cs_q[1:0], spi_cs_n};
      mosi_q      <= {mosi_q[0], spi_mosi};
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_ok_q  <= frame_ok_d;
      digit_q     <= digit_d;
      mask_q      <= mask_d;
      disp_en_q   <= disp_en_d;
      scan_cnt_q  <= scan_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      idx_q       <= idx_d;
      phase_q     <= phase_d;
      seg_q       <= seg_d;
      en_q        <= en_d;
    end
  end

  assign seg_out  = seg_q;
  assign digit_en = en_q;
  assign frame_ok = frame_ok_q;

endmodule

// File: tb/tb_spi_segment_scanner.sv
// Scoreboarded bench: frames queue their expected effect; the monitor applies it on frame_ok
// and compares every output cycle against an arithmetic scan/blink reference.
module tb_spi_segment_scanner;

  localparam int unsigned ND    = 4;
  localparam int unsigned SCAN  = 4;
  localparam int unsigned BLINK = 8;

  logic clk = 1'b0;
  logic rst_n, ena, sclk, mosi, cs_n;
  logic [7:0]    seg_out;
  logic [ND-1:0] digit_en;
  logic          frame_ok;

  spi_segment_scanner #(
    .NUM_DIGITS (ND),
    .SCAN_COUNT (24'(SCAN)),
    .BLINK_COUNT(24'(BLINK))
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .spi_sclk(sclk),
    .spi_mosi(mosi),
    .spi_cs_n(cs_n),
    .seg_out (seg_out),
    .digit_en(digit_en),
    .frame_ok(frame_ok)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference state: what the display registers hold, plus count of enabled cycles since reset.
  logic [7:0]    m_dig [ND];
  logic [ND-1:0] m_mask;
  logic          m_disp;
  int unsigned   c;

  task automatic model_reset();
    for (int i = 0; i < int'(ND); i++) m_dig[i] = 8'h00;
    m_mask = '0;
    m_disp = 1'b1;
    c      = 0;
  endtask

  task automatic apply(input logic [15:0] f);
    case (f[15:12])
      4'd1: if (f[11:8] < 4'(ND)) m_dig[f[9:8]] = f[7:0];
      4'd2: if (f[11:8] < 4'(ND)) m_dig[f[9:8]] = {f[7], hex_tab[f[3:0]]};
      4'd3: m_mask = f[ND-1:0];
      4'd4: m_disp = f[0];
      default: ;
    endcase
  endtask

  // Monitor
  initial begin
    logic [ND-1:0] e_en;
    logic [7:0]    e_seg;
    logic          e_fo_zero;
    logic [1:0]    k;
    logic          ph;
    model_reset();
    forever begin
      @(posedge clk);
      #1;
      e_en = '0; e_seg = '0; e_fo_zero = 1'b1;
      if (!rst_n) begin
        model_reset();
        exp_q.delete();
      end else if (ena) begin
        e_fo_zero = 1'b0;
        k  = 2'((c / SCAN) % ND);
        ph = 1'((c / BLINK) % 2);
        e_en  = m_disp ? ND'(1 << k) : '0;
        e_seg = (!m_disp || (m_mask[k] && ph)) ? 8'h00 : m_dig[k];
        c++;
      end
      tests++;
      if (digit_en !== e_en || seg_out !== e_seg || (e_fo_zero && frame_ok !== 1'b0)) begin
        fails++;
        $display("FAIL outputs t=%0t: digit_en=%b seg_out=%h frame_ok=%b, required digit_en=%b seg_out=%h%s",
                 $time, digit_en, seg_out, frame_ok, e_en, e_seg, e_fo_zero ? " frame_ok=0" : "");
      end
      if (rst_n && frame_ok === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL frame_ok t=%0t: pulse seen, required no pulse (no frame pending)", $time);
        end else begin
          apply(exp_q.pop_front());
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends the low n bits of bits MSB first; valid frames are queued at cs_n rise.
  task automatic send(input logic [16:0] bits, input int n, input bit valid);
    @(negedge clk);
    cs_n = 1'b0;
    idle(2);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = bits[i];
      idle(2);
      sclk = 1'b1;
      idle(2);
      sclk = 1'b0;
    end
    idle(2);
    cs_n = 1'b1;
    if (valid) begin
      exp_q.push_back(bits[15:0]);
      for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clk);
      tests++;
      if (exp_q.size() != 0) begin
        fails++;
        $display("FAIL commit_timeout frame=%h: frame_ok not seen within 10 cycles, required one pulse", bits[15:0]);
        exp_q.delete();
      end
    end
    idle(8);
  endtask

  task automatic send16(input logic [15:0] f);
    send({1'b0, f}, 16, 1'b1);
  endtask

  initial begin
    logic [15:0] f;
    int          len;
    rst_n = 1'b0; ena = 1'b1; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1;
    idle(5);
    rst_n = 1'b1;
    idle(40);

    send16(16'h218A);
    send({1'b0, 16'h10FF} >> 1, 15, 1'b0);
    send({16'h10FF, 1'b1}, 17, 1'b0);
    idle(20);

    send16(16'h103F);
    send16(16'h1155);
    send16(16'h3001);
    idle(80);

    send16(16'h4000);
    idle(30);
    send16(16'h4001);
    idle(30);
    send16(16'h17AA);
    send16(16'h3000);
    idle(20);

    @(negedge clk);
    ena = 1'b0;
    idle(5);
    send16_disabled: begin
      send({1'b0, 16'h1299}, 16, 1'b0);
    end
    idle(10);
    ena = 1'b1;
    idle(30);

    for (int v = 0; v < 16; v++) begin
      send16({4'd2, 4'(v % 4), 4'(v), 4'(v)});
      idle(16);
    end

    for (int i = 0; i < 40; i++) begin
      f[15:12] = 4'($urandom_range(0, 5));
      f[11:8]  = ($urandom % 4 == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      f[7:0]   = 8'($urandom);
      if (f[15:12] == 4'd4 && $urandom % 4 != 0) f[0] = 1'b1;
      len = ($urandom % 8 == 0) ? (($urandom % 2 == 0) ? 15 : 17) : 16;
      if (len == 16)      send({1'b0, f}, 16, 1'b1);
      else if (len == 15) send({1'b0, f} >> 1, 15, 1'b0);
      else                send({f, 1'b0}, 17, 1'b0);
      idle(int'($urandom_range(0, 20)));
    end

    // Reset in the middle of a frame
    @(negedge clk);
    cs_n = 1'b0;
    idle(2);
    for (int i = 15; i >= 8; i--) begin
      mosi = 1'(16'h2307 >> i);
      idle(2);
      sclk = 1'b1;
      idle(2);
      sclk = 1'b0;
    end
    rst_n = 1'b0;
    idle(3);
    cs_n = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(30);
    send16(16'h2307);
    idle(40);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_frames: %0d still queued, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
